// File: rtl/dec_digit_assembler.sv
// Serial BCD digit receiver: accumulates MSD-first digits into a 16-bit binary value
// and presents it on a held valid/ready output. Optional macro: DIGIT_CHECK_EN.
module dec_digit_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_digit,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_value,
    output logic [2:0]  out_ndigits,
    output logic        out_ovf,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_OUT = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_acc;
    logic [2:0]  r_ndig;
    logic        r_ovf;

    logic        w_accept;
    logic        w_consume;
    logic [3:0]  w_dig_eff;
    logic [19:0] w_sum;
    logic [2:0]  w_ndig_next;

    assign in_ready  = (r_state == S_ACC);
    assign out_valid = (r_state == S_OUT);
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

`ifdef DIGIT_CHECK_EN
    logic w_bad_dig;
    logic r_err;

    // Non-BCD digits contribute zero but flag the whole number as erroneous.
    assign w_bad_dig = (in_digit > 4'd9);
    assign w_dig_eff = w_bad_dig ? 4'd0 : in_digit;
    assign out_err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_consume) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= r_err | w_bad_dig;
        end
    end
`else
    assign w_dig_eff = in_digit;
    assign out_err   = 1'b0;
`endif

    // 20 bits holds 65535*10 + 15 without wrapping, so bits above 15 signal overflow.
    assign w_sum       = ({4'd0, r_acc} * 20'd10) + {16'd0, w_dig_eff};
    assign w_ndig_next = (r_ndig == 3'd7) ? 3'd7 : r_ndig + 3'd1;

    assign out_value   = r_acc;
    assign out_ndigits = r_ndig;
    assign out_ovf     = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACC;
            r_acc   <= 16'd0;
            r_ndig  <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        r_acc  <= w_sum[15:0];
                        r_ovf  <= r_ovf | (w_sum[19:16] != 4'd0);
                        r_ndig <= w_ndig_next;
                        if (in_last) begin
                            r_state <= S_OUT;
                        end
                    end
                end
                default: begin
                    if (w_consume) begin
                        r_acc   <= 16'd0;
                        r_ndig  <= 3'd0;
                        r_ovf   <= 1'b0;
                        r_state <= S_ACC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_digit_assembler.sv
// Bench for dec_digit_assembler: arithmetic reference model plus directed numbers
// with hand-computed literal results.
module tb_dec_digit_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_value;
    logic [2:0]  out_ndigits;
    logic        out_ovf;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    dec_digit_assembler dut (
        .clk         (clk),
        .rst         (rst),
        .in_digit    (in_digit),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_value   (out_value),
        .out_ndigits (out_ndigits),
        .out_ovf     (out_ovf),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int n;
        int ovf;
        int err;
    } res_t;

    res_t    exp_q[$];
    longint  m_true = 0;
    int      m_cnt  = 0;
    int      m_err  = 0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: exact integer value of the accepted digits.
    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                int d;
                d = int'(in_digit);
`ifdef DIGIT_CHECK_EN
                if (d > 9) begin
                    d = 0;
                    m_err = 1;
                end
`endif
                m_true = m_true * 10 + longint'(d);
                m_cnt++;
                if (in_last) begin
                    res_t r;
                    r.v   = int'(m_true % 65536);
                    r.n   = (m_cnt > 7) ? 7 : m_cnt;
                    r.ovf = (m_true > 65535) ? 1 : 0;
                    r.err = m_err;
                    exp_q.push_back(r);
                    m_true = 0;
                    m_cnt  = 0;
                    m_err  = 0;
                end
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge rst) begin
        exp_q.delete();
        m_true = 0;
        m_cnt  = 0;
        m_err  = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_out_valid", int'(out_valid), (exp_q.size() != 0) ? 1 : 0);
            chk("mdl_in_ready", int'(in_ready), (exp_q.size() == 0) ? 1 : 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("mdl_value", int'(out_value), exp_q[0].v);
                chk("mdl_ndigits", int'(out_ndigits), exp_q[0].n);
                chk("mdl_ovf", int'(out_ovf), exp_q[0].ovf);
                chk("mdl_err", int'(out_err), exp_q[0].err);
            end
        end
    end

    // Digits packed as hex nibbles, most significant digit in the highest used nibble.
    task automatic send_num(input int n, input logic [31:0] packed_d, input logic last_flag);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_digit = packed_d[(n - 1 - i) * 4 +: 4];
            in_last  = last_flag && (i == n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_digit = 4'd0;
    endtask

    task automatic get_result(input string nm, input int v, input int n, input int ovf,
                              input int err);
        int waited;
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1", nm);
        end else begin
            chk({nm, "_value"}, int'(out_value), v);
            chk({nm, "_ndigits"}, int'(out_ndigits), n);
            chk({nm, "_ovf"}, int'(out_ovf), ovf);
            chk({nm, "_err"}, int'(out_err), err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_value"}, int'(out_value), 0);
        chk({nm, "_ndigits"}, int'(out_ndigits), 0);
        chk({nm, "_ovf"}, int'(out_ovf), 0);
        chk({nm, "_err"}, int'(out_err), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_digit  = 4'd0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        send_num(4, 32'h4321, 1'b1);
        chk("latency_valid", int'(out_valid), 1);
        get_result("n4321", 4321, 4, 0, 0);

        send_num(5, 32'h65535, 1'b1);
        get_result("n65535", 65535, 5, 0, 0);
        send_num(5, 32'h65536, 1'b1);
        get_result("n65536", 0, 5, 1, 0);

        send_num(1, 32'h0, 1'b1);
        get_result("n0", 0, 1, 0, 0);

        // 11111111 mod 65536 = 35527
        send_num(8, 32'h11111111, 1'b1);
        get_result("n1x8", 35527, 7, 1, 0);

        send_num(2, 32'h72, 1'b1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_digit = 4'd5;
            in_last  = 1'b1;
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_value", int'(out_value), 72);
            chk("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result("bp72", 72, 2, 0, 0);
        send_num(1, 32'h9, 1'b1);
        get_result("after_bp9", 9, 1, 0, 0);

        send_num(2, 32'h12, 1'b0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid_num");
        @(negedge clk);
        rst = 1'b0;
        send_num(1, 32'h5, 1'b1);
        get_result("after_rst5", 5, 1, 0, 0);

        send_num(1, 32'h3, 1'b1);
        chk("pre_rst_out_valid", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid_out");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_num(3, 32'h1A3, 1'b1);
`ifdef DIGIT_CHECK_EN
        get_result("n1A3", 103, 3, 0, 1);
`else
        get_result("n1A3", 203, 3, 0, 0);
`endif
        send_num(2, 32'h42, 1'b1);
        get_result("err_cleared", 42, 2, 0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
